// File: rtl/systolic_array_feeder.sv
// Sequencer for a 1xN systolic MAC array: streams activation/weight tiles from the
// buffers into the PEs and writes each requantised result to the result buffer.
module systolic_array_feeder #(
  parameter int unsigned MAC_NUM   = 10,
  parameter int unsigned BW_ACT    = 8,
  parameter int unsigned BW_WET    = 8,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned ARRAY_LAT = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           cfg_num_out,
  input  logic [ADDR_W-1:0]           cfg_num_tile,
  input  logic [7:0]                  cfg_shift,
  output logic                        busy,
  output logic                        done,
  output logic                        act_rd_en,
  output logic [ADDR_W-1:0]           act_rd_addr,
  input  logic [MAC_NUM*BW_ACT-1:0]   act_rd_data,
  output logic                        wet_rd_en,
  output logic [ADDR_W-1:0]           wet_rd_addr,
  input  logic [MAC_NUM*BW_WET-1:0]   wet_rd_data,
  output logic                        PE_mac_enable,
  output logic                        PE_clear_acc,
  output logic signed [BW_ACT-1:0]    PE_act_out [MAC_NUM],
  output logic signed [BW_WET-1:0]    PE_wet_out [MAC_NUM],
  output logic [7:0]                  PE_res_shift_num,
  input  logic signed [BW_ACT-1:0]    PE_result_in,
  output logic                        res_we,
  output logic [ADDR_W-1:0]           res_addr,
  output logic [BW_ACT-1:0]           res_data
);

  localparam int unsigned    LAT_W    = (ARRAY_LAT > 1) ? $clog2(ARRAY_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ARRAY_LAT - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] num_out_q, num_out_d;
  logic [ADDR_W-1:0] num_tile_q, num_tile_d;
  logic [ADDR_W-1:0] o_q, o_d;
  logic [ADDR_W-1:0] t_q, t_d;
  logic [ADDR_W-1:0] w_q, w_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [7:0]        shift_d;
  logic              busy_d, done_d, rd_en_d, mac_en_d, clear_d, res_we_d;

  always_comb begin
    state_d    = state_q;
    num_out_d  = num_out_q;
    num_tile_d = num_tile_q;
    o_d        = o_q;
    t_d        = t_q;
    w_d        = w_q;
    lat_d      = lat_q;
    shift_d    = PE_res_shift_num;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_out_d  = cfg_num_out;
          num_tile_d = cfg_num_tile;
          shift_d    = cfg_shift;
          o_d        = '0;
          t_d        = '0;
          w_d        = '0;
          state_d    = (cfg_num_out == '0 || cfg_num_tile == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Weight address is a running count: it equals o*num_tile+t without a multiplier.
        w_d = w_q + ADDR_W'(1);
        if (t_q == num_tile_q - ADDR_W'(1)) begin
          t_d     = '0;
          lat_d   = '0;
          state_d = DRAIN;
        end else begin
          t_d = t_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (lat_q == LAT_LAST) state_d = WRITE;
        else                   lat_d   = lat_q + LAT_W'(1);
      end
      WRITE: begin
        o_d     = o_q + ADDR_W'(1);
        state_d = (o_d == num_out_q) ? DONE : RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    busy_d   = (state_d == RUN) || (state_d == DRAIN) || (state_d == WRITE);
    done_d   = (state_d == DONE);
    rd_en_d  = (state_d == RUN);
    res_we_d = (state_d == WRITE);
    mac_en_d = act_rd_en;
    clear_d  = act_rd_en && (act_rd_addr == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      num_out_q        <= '0;
      num_tile_q       <= '0;
      o_q              <= '0;
      t_q              <= '0;
      w_q              <= '0;
      lat_q            <= '0;
      PE_res_shift_num <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      act_rd_en        <= 1'b0;
      act_rd_addr      <= '0;
      wet_rd_en        <= 1'b0;
      wet_rd_addr      <= '0;
      PE_mac_enable    <= 1'b0;
      PE_clear_acc     <= 1'b0;
      res_we           <= 1'b0;
      res_addr         <= '0;
    end else begin
      state_q          <= state_d;
      num_out_q        <= num_out_d;
      num_tile_q       <= num_tile_d;
      o_q              <= o_d;
      t_q              <= t_d;
      w_q              <= w_d;
      lat_q            <= lat_d;
      PE_res_shift_num <= shift_d;
      busy             <= busy_d;
      done             <= done_d;
      act_rd_en        <= rd_en_d;
      act_rd_addr      <= rd_en_d ? t_d : '0;
      wet_rd_en        <= rd_en_d;
      wet_rd_addr      <= rd_en_d ? w_d : '0;
      PE_mac_enable    <= mac_en_d;
      PE_clear_acc     <= clear_d;
      res_we           <= res_we_d;
      res_addr         <= res_we_d ? o_d : '0;
    end
  end

  // Buffer read data and the array result only exist in the cycle they are consumed,
  // so they are gated straight through by the registered enables.
  always_comb begin
    for (int unsigned i = 0; i < MAC_NUM; i++) begin
      PE_act_out[i] = PE_mac_enable ? act_rd_data[i*BW_ACT +: BW_ACT] : '0;
      PE_wet_out[i] = PE_mac_enable ? wet_rd_data[i*BW_WET +: BW_WET] : '0;
    end
  end

  assign res_data = res_we ? PE_result_in : '0;

endmodule
